// File: rtl/bp_pkg.sv
// bp_pkg: shared types, constants and helpers for branch_predictor.
//   bp_entry_t     : one BTB entry (valid, tag, target)
//   SNT/WNT/WT/ST  : 2-bit counter states; ctr_wnt()/ctr_wt() generalise them to any width
//   bp_index/bp_tag: PC slicing helpers (callers truncate to IDX_W / TAG_W)
package bp_pkg;

  localparam int BP_ADDR_W = 32;
  localparam int BP_TAG_W  = 8;

  // Counter states for the default 2-bit counter.
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // BTB entry. The field widths fix the ADDR_W/TAG_W the top is built with.
  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
  } bp_entry_t;

  // Weakly-not-taken / weakly-taken encodings for a ctr_w-bit counter.
  function automatic int ctr_wnt(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  function automatic int ctr_wt(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // pc[1:0] is dropped; the index sits directly above it.
  function automatic logic [BP_ADDR_W-1:0] bp_index(input logic [BP_ADDR_W-1:0] pc);
    return pc >> 2;
  endfunction

  // Tag sits directly above the index bits.
  function automatic logic [BP_ADDR_W-1:0] bp_tag(input logic [BP_ADDR_W-1:0] pc,
                                                  input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: CTR_W-bit saturating up/down counter with load.
//   clk, rst (async, active-low) -> q = RST_VAL
//   ld/ld_val : load has priority over inc/dec
//   inc/dec   : saturate at all-ones / zero
//   q         : current counter value
module bp_sat_counter #(
  parameter int               CTR_W   = 2,
  parameter logic [CTR_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [CTR_W-1:0] ld_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 q <= RST_VAL;
    else if (ld)              q <= ld_val;
    else if (inc && q != '1)  q <= q + CTR_W'(1);
    else if (dec && q != '0)  q <= q - CTR_W'(1);
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BHT (saturating counters) + tagged BTB.
// Lookup is registered: the prediction for lk_pc appears the cycle after lk_valid.
//   clk, rst (async, active-low)
//   lk_valid, lk_pc                -> pred_valid, pred_hit, pred_taken, pred_target
//   upd_valid, upd_pc, upd_taken, upd_target : resolved branch from execute
// Optional: define BP_GSHARE_EN to XOR a global history register into the
// counter index (BTB index/tag stay PC-only).
// ADDR_W / TAG_W must match the bp_entry_t field widths in bp_pkg.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W = BP_ADDR_W,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = BP_TAG_W,
  parameter int CTR_W  = 2,
  parameter int GHR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int               ENTRIES = 1 << IDX_W;
  localparam int               STAGES  = 1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_wnt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_wt(CTR_W));

  bp_entry_t                    tbl [ENTRIES];
  logic [ENTRIES-1:0][CTR_W-1:0] ctr_q;
  logic [STAGES:1]              vld_pipe;

  logic [IDX_W-1:0] lk_idx, upd_idx, lk_cidx, upd_cidx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  bp_entry_t        lk_ent, upd_ent;
  logic             lk_hit, lk_taken, upd_hit;
  logic             ctr_ld, ctr_inc, ctr_dec;

  assign lk_idx  = IDX_W'(bp_index(lk_pc));
  assign upd_idx = IDX_W'(bp_index(upd_pc));
  assign lk_tag  = TAG_W'(bp_tag(lk_pc, IDX_W));
  assign upd_tag = TAG_W'(bp_tag(upd_pc, IDX_W));

`ifdef BP_GSHARE_EN
  // History shifts on every resolved branch; both ports see the pre-shift value.
  logic [GHR_W-1:0] ghr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           ghr <= '0;
    else if (upd_valid) ghr <= GHR_W'({ghr, upd_taken});
  end

  assign lk_cidx  = lk_idx  ^ IDX_W'(ghr);
  assign upd_cidx = upd_idx ^ IDX_W'(ghr);
`else
  assign lk_cidx  = lk_idx;
  assign upd_cidx = upd_idx;
`endif

  assign lk_ent   = tbl[lk_idx];
  assign upd_ent  = tbl[upd_idx];
  assign lk_hit   = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign upd_hit  = upd_ent.valid && (upd_ent.tag == upd_tag);
  assign lk_taken = lk_hit && ctr_q[lk_cidx][CTR_W-1];

  // Hit trains the counter; a taken miss allocates and seeds it weakly-taken.
  assign ctr_inc = upd_valid &&  upd_hit &&  upd_taken;
  assign ctr_dec = upd_valid &&  upd_hit && !upd_taken;
  assign ctr_ld  = upd_valid && !upd_hit &&  upd_taken;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = (upd_cidx == IDX_W'(i));

    bp_sat_counter #(
      .CTR_W   (CTR_W),
      .RST_VAL (CTR_WNT)
    ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .ld     (ctr_ld  && sel),
      .ld_val (CTR_WT),
      .inc    (ctr_inc && sel),
      .dec    (ctr_dec && sel),
      .q      (ctr_q[i])
    );
  end

  // Any taken update writes the whole entry: on a hit the tag is unchanged and
  // only the target refreshes, on a miss the occupant is replaced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (upd_valid && upd_taken) begin
      tbl[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
    end
  end

  // Lookup reads the table combinationally from pre-edge state, so a same-cycle
  // update to the same index is not visible until the next lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe    <= '0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      vld_pipe[1] <= lk_valid;
      if (lk_valid) begin
        pred_hit    <= lk_hit;
        pred_taken  <= lk_taken;
        pred_target <= lk_taken ? lk_ent.target : lk_pc + ADDR_W'(4);
      end
    end
  end

  assign pred_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .lk_valid    (lk_valid),
    .lk_pc       (lk_pc),
    .pred_valid  (pred_valid),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  typedef struct {
    logic        lk_v;
    logic [31:0] lk_pc;
    logic        up_v;
    logic [31:0] up_pc;
    logic        up_t;
    logic [31:0] up_tgt;
    logic        e_hit;
    logic        e_tkn;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_pred(input string tag, input logic v, input logic h, input logic t,
                          input logic [31:0] tg);
    chk({tag, ".valid"},  {31'd0, pred_valid}, {31'd0, v});
    chk({tag, ".hit"},    {31'd0, pred_hit},   {31'd0, h});
    chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, t});
    chk({tag, ".target"}, pred_target,         tg);
  endtask

  function automatic void lk(input logic [31:0] pc, input logic h, input logic t,
                             input logic [31:0] tg);
    vt.push_back('{1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, h, t, tg});
  endfunction

  function automatic void up(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    vt.push_back('{1'b0, 32'd0, 1'b1, pc, t, tg, 1'b0, 1'b0, 32'd0});
  endfunction

  function automatic void both(input logic [31:0] lpc, input logic [31:0] upc,
                               input logic t, input logic [31:0] utg,
                               input logic h, input logic et, input logic [31:0] etg);
    vt.push_back('{1'b1, lpc, 1'b1, upc, t, utg, h, et, etg});
  endfunction

  task automatic drive_idle();
    lk_valid = 1'b0; lk_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] pc, input logic h,
                           input logic t, input logic [31:0] tg);
    @(negedge clk);
    drive_idle();
    lk_valid = 1'b1; lk_pc = pc;
    @(posedge clk); #1;
    chk_pred(tag, 1'b1, h, t, tg);
  endtask

  initial begin
    logic        hold_h, hold_t;
    logic [31:0] hold_tg;

    // Counter starts WNT (1). Index = pc[7:2], tag = pc[15:8].
    lk(32'h100, 0, 0, 32'h104);                 // cold miss
    up(32'h100, 1, 32'h80);                     // allocate, ctr=2; no lookup -> hold
    lk(32'h100, 1, 1, 32'h80);
    up(32'h100, 0, 0); up(32'h100, 0, 0);       // 2->1->0
    up(32'h100, 0, 0); up(32'h100, 0, 0);       // stays 0
    lk(32'h100, 1, 0, 32'h104);
    up(32'h100, 0, 0);                          // fifth not-taken, still 0
    both(32'h100, 32'h100, 1, 32'h80, 1, 0, 32'h104); // sees ctr 0, then ->1
    lk(32'h100, 1, 0, 32'h104);                 // ctr 1 (no wrap from 0 to max)
    up(32'h100, 1, 32'h80);                     // ->2
    lk(32'h100, 1, 1, 32'h80);
    up(32'h100, 1, 32'h80); up(32'h100, 1, 32'h80); // ->3, stays 3
    up(32'h100, 0, 0);                          // ->2
    lk(32'h100, 1, 1, 32'h80);                  // still taken: top saturated
    up(32'h200, 1, 32'h200);                    // same index, tag 2: evicts 0x100
    lk(32'h100, 0, 0, 32'h104);
    lk(32'h200, 1, 1, 32'h200);
    up(32'h300, 0, 0);                          // not-taken miss: no allocation
    lk(32'h200, 1, 1, 32'h200);
    lk(32'h300, 0, 0, 32'h304);
    both(32'h40, 32'h40, 1, 32'h10, 0, 0, 32'h44); // read-before-write
    lk(32'h40, 1, 1, 32'h10);
    lk(32'h43, 1, 1, 32'h10);                   // pc[1:0] ignored
    lk(32'hFFFF_FFFC, 0, 0, 32'h0);             // pc+4 wraps
    lk(32'h4040, 0, 0, 32'h4044);               // same index, tag mismatch

    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_pred("reset", 0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    hold_h = 1'b0; hold_t = 1'b0; hold_tg = '0;
    foreach (vt[i]) begin
      @(negedge clk);
      lk_valid   = vt[i].lk_v;
      lk_pc      = vt[i].lk_pc;
      upd_valid  = vt[i].up_v;
      upd_pc     = vt[i].up_pc;
      upd_taken  = vt[i].up_t;
      upd_target = vt[i].up_tgt;
      @(posedge clk); #1;
      if (vt[i].lk_v) begin
        hold_h = vt[i].e_hit; hold_t = vt[i].e_tkn; hold_tg = vt[i].e_tgt;
      end
      chk_pred($sformatf("vec%0d", i), vt[i].lk_v, hold_h, hold_t, hold_tg);
    end

    // Reset pulse while a lookup is in flight.
    @(negedge clk);
    drive_idle();
    lk_valid = 1'b1; lk_pc = 32'h40;
    #2 rst = 1'b0;
    #1 chk_pred("rst_async", 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    chk_pred("rst_edge", 0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    lk_valid = 1'b0;
    @(posedge clk); #1;
    chk_pred("rst_after", 0, 0, 0, 32'h0);
`ifdef BP_GSHARE_EN
    chk("rst_ghr", 32'(dut.ghr), 32'h0);
`endif
    do_lookup("post_rst_40",  32'h40,  0, 0, 32'h44);
    do_lookup("post_rst_200", 32'h200, 0, 0, 32'h204);

    @(negedge clk);
    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised direct-mapped branch predictor (a BHT of saturating counters plus a tagged BTB) for the cpu_top fetch stage. It generalises fixed "beq taken" handling: fetch gets a predicted next PC, and execute writes back the resolved outcome. Lookups are registered, so the prediction arrives one cycle after the PC is presented.

Parameters:
ADDR_W, 32, PC / target width
IDX_W, 6, log2 of entry count (64 entries)
TAG_W, 8, tag bits stored per entry
CTR_W, 2, saturating counter width (≥2)
GHR_W, 6, global history length (used only with BP_GSHARE_EN; must be ≤ IDX_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
lk_valid  in  1  lookup request this cycle
lk_pc  in  ADDR_W  fetch PC to predict
pred_valid  out  1  prediction valid (lk_valid delayed 1 cycle)
pred_hit  out  1  BTB tag hit
pred_taken  out  1  predicted taken
pred_target  out  ADDR_W  predicted next PC
upd_valid  in  1  resolved conditional branch from execute
upd_pc  in  ADDR_W  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  ADDR_W  actual taken target

Behaviour:
- Reset (rst=0, async): all entry valid bits = 0; counters = weakly-not-taken (2^(CTR_W-1)-1); GHR = 0; pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0. Reset mid-lookup discards the in-flight prediction.
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Lookup latency is 1 cycle. On the edge where lk_valid=1, register pred_valid=1, pred_hit = entry.valid && tag match, pred_taken = pred_hit && counter MSB, and pred_target = pred_taken ? entry.target : lk_pc+4 (mod 2^ADDR_W). When lk_valid=0, the next cycle has pred_valid=0 and the other outputs hold.
- Update (upd_valid=1), applied on the clock edge:
  - Hit: counter increments on taken and decrements on not-taken, saturating at all-ones and 0. Target is written only if upd_taken.
  - Miss, taken: allocate the entry (valid=1, tag, target=upd_target, counter=weakly-taken 2^(CTR_W-1)). This overwrites any occupant.
  - Miss, not-taken: no allocation; the table is unchanged.
- Lookup and update in the same cycle to the same index: the lookup returns the pre-update contents (read-before-write). The update still commits.
- Aliasing: different PCs with the same index and tag share an entry by design.
- No stalls and no backpressure. Both ports accept a request every cycle.

Optional Feature:
BP_GSHARE_EN
- Defined: a GHR_W-bit global history register shifts left and takes upd_taken into its LSB on every upd_valid. The counter index becomes index XOR {0, GHR}. Lookup uses the current GHR; update uses the GHR value before its own shift. BTB index/tag stay PC-only.
- Not defined: no GHR exists; the counter index equals the PC index (bimodal). GHR_W is ignored.

Decomposition:
- Package bp_pkg holds:
  - entry struct: valid, tag, target
  - counter-state localparams: SNT=0, WNT, WT, ST=max
  - helper function for the index/tag slice
- One sub-module, bp_sat_counter: CTR_W saturating inc/dec with reset value. Instantiated per entry or used as a function-equivalent update path.
- Tables are flop arrays; no RAM macro.

Test Plan:
- After reset, lk_pc=0x100 → next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x104.
- upd(pc=0x100, taken, target=0x80), then lookup 0x100 → hit=1, taken=1, target=0x80.
- Four upd not-taken to 0x100 → counter saturates at 0; lookup gives taken=0, target=0x104. A fifth not-taken leaves the counter at 0.
- Conflict: 0x100 allocated; upd taken pc=0x100+(1<<(IDX_W+2)) target=0x200 → lookup 0x100 misses; the new PC hits with target=0x200.
- Same-cycle lookup/update to a fresh 0x40 (taken, target=0x10) → that cycle's prediction is miss/0x44; the following lookup hits with 0x10.
- Assert rst low for 1 cycle between a lk_valid and its response → pred_valid=0 and all entries invalid; with BP_GSHARE_EN, the GHR reads 0.
